mojo_serial_line_in: RTL and testbench
======================================

Name: mojo_serial_line_in

Overview:
- Receive-side framer for the CR/LF-terminated line format that the serial block transmitter path emits.
- Sits between the AVR interface UART receive outputs (rx_data/new_rx_data) and user logic.
- Accumulates bytes until CR (8'h0D) followed by LF (8'h0A), then presents the line as a wide parallel block plus byte count.
- Lines too long for the buffer are dropped and flagged.

Parameters:
- MAX_BYTES, 40, maximum payload bytes per line, excluding the CR/LF terminator.
- LEN_W, 6, width of rx_len; must satisfy 2^LEN_W > MAX_BYTES.
- TIMEOUT_CYCLES, 50000000, idle cycles before a partial line is discarded. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- rx_data  input  8  received byte; valid only when new_rx_data=1.
- new_rx_data  input  1  single-cycle strobe qualifying rx_data.
- rx_block  output  MAX_BYTES*8  completed line payload.
- rx_len  output  LEN_W  number of valid payload bytes in rx_block.
- new_rx_block  output  1  single-cycle pulse; rx_block and rx_len are valid on this cycle.
- overflow  output  1  single-cycle pulse when a line is dropped for length.

Behaviour:
- Reset: clock is clk; reset is synchronous, active-low on rst_n. While rst_n=0, the following are all zero: rx_block, rx_len, new_rx_block, overflow, the internal buffer, and the byte count. State goes to COLLECT.
- Reset mid-line discards the partial line; nothing is emitted.
- Packing: first received payload byte occupies rx_block[MAX_BYTES*8-1 -: 8]; byte i occupies [8*(MAX_BYTES-i)-1 -: 8]. Unused low bytes read 8'h00.
- Output stability: rx_block and rx_len are output registers. They are loaded only on the cycle new_rx_block rises and hold until the next emission. The working buffer is separate, so reception of the next line does not disturb them.
- Bytes are processed only on cycles where new_rx_data=1. Other cycles hold state.
- State COLLECT:
  - Byte 8'h0D -> GOT_CR (CR is not yet stored).
  - Any other byte, including a bare LF: if count<MAX_BYTES, store it and increment count; else pulse overflow and go to DISCARD.
- State GOT_CR:
  - LF with count>0 -> emit, clear buffer and count -> COLLECT.
  - LF with count=0 (empty line) -> no emission -> COLLECT.
  - CR -> the first CR is stored as data (overflow rule applies); stay in GOT_CR.
  - Other byte -> the stored-CR and the byte are appended as data, in order, consuming 2 slots. If either does not fit: overflow -> DISCARD.
- State DISCARD:
  - Bytes are ignored.
  - CR -> DISCARD_CR.
- State DISCARD_CR:
  - LF -> clear buffer and count -> COLLECT; no emission.
  - CR -> stay in DISCARD_CR.
  - Other byte -> DISCARD.
- Latency: new_rx_block and the updated rx_block/rx_len assert exactly 1 cycle after the clock edge sampling the terminating LF. overflow asserts 1 cycle after the offending byte.
- A full line of exactly MAX_BYTES followed by CRLF is legal: emits with rx_len=MAX_BYTES.
- new_rx_block and overflow never assert together.
- Back-to-back strobes (new_rx_data on consecutive cycles) must be handled with no byte loss.

Optional Feature:
- Macro: MOJO_SERIAL_LINE_IN_TIMEOUT_EN.
- Defined:
  - A counter runs while in GOT_CR, DISCARD, DISCARD_CR, or COLLECT with count>0. It resets to 0 on every new_rx_data.
  - On reaching TIMEOUT_CYCLES-1, clear buffer and count and return to COLLECT. No pulse is generated.
- Undefined: no counter; a partial line persists indefinitely. The TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Shared package mojo_serial_pkg holds:
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A, also used by the block transmitter path;
  - the state enum {COLLECT, GOT_CR, DISCARD, DISCARD_CR}.
- One natural sub-module: mojo_line_buffer. It holds the byte-append shift register and count, with:
  - an append-1 / append-2 interface;
  - a clear input;
  - a full flag.
- The FSM and output registers stay in the top of this block.

Test Plan:
- Send "AB",0D,0A -> one new_rx_block 1 cycle after LF; rx_len=2; rx_block top 16 bits 16'h4142; remaining bits zero; overflow never pulses.
- Send 40 bytes 8'h30..8'h57, then 0D,0A -> rx_len=40; rx_block[319:312]=8'h30, rx_block[7:0]=8'h57.
- Send 41 bytes, then 0D,0A, then "Z",0D,0A:
  - overflow pulses once, 1 cycle after the 41st byte;
  - no emission for the long line;
  - next emission has rx_len=1, top byte 8'h5A.
- Send "A",0D,"B",0D,0D,0A,0A,0D,0A:
  - first emission: rx_len=4, bytes 41,0D,42,0D;
  - second emission: rx_len=1, byte 0A.
- Send 0D,0A alone -> no pulse. Then drive rst_n=0 for 1 cycle after "XY" -> outputs zero. Then "Q",0D,0A -> rx_len=1, byte 8'h51.
- With MOJO_SERIAL_LINE_IN_TIMEOUT_EN and TIMEOUT_CYCLES=100: send "AB", idle 100 cycles, then "C",0D,0A -> rx_len=1, byte 8'h43. Without the macro, same stimulus -> rx_len=3.

Source files
------------

// File: rtl/mojo_serial_pkg.sv
// Shared definitions for the mojo serial line framing blocks.
// ASCII_CR/ASCII_LF are the line terminator bytes, which the block transmitter
// path also uses. line_state_t is the receive framer state.
package mojo_serial_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        COLLECT,
        GOT_CR,
        DISCARD,
        DISCARD_CR
    } line_state_t;

endpackage

// File: rtl/mojo_line_buffer.sv
// Working line buffer for mojo_serial_line_in.
// Appends one or two bytes per cycle. Byte i is stored at
// line_buf[8*(MAX_BYTES-i)-1 -: 8], so the first byte is the most significant.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clear          zero the buffer and count (takes priority over append)
//   append1        store byte_a at slot count
//   append2        store byte_a at slot count and byte_b at slot count+1
//   byte_a, byte_b bytes to append
//   line_buf       buffer contents
//   count          number of stored bytes
//   full           count == MAX_BYTES
module mojo_line_buffer #(
    parameter int unsigned MAX_BYTES = 40,
    parameter int unsigned LEN_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   append1,
    input  logic                   append2,
    input  logic [7:0]             byte_a,
    input  logic [7:0]             byte_b,
    output logic [MAX_BYTES*8-1:0] line_buf,
    output logic [LEN_W-1:0]       count,
    output logic                   full
);

    assign full = (count == LEN_W'(MAX_BYTES));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            line_buf <= '0;
            count    <= '0;
        end else if (append1 || append2) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                if (LEN_W'(i) == count)
                    line_buf[8*(MAX_BYTES-i)-1 -: 8] <= byte_a;
                if (append2 && (LEN_W'(i) == count + LEN_W'(1)))
                    line_buf[8*(MAX_BYTES-i)-1 -: 8] <= byte_b;
            end
            count <= count + (append2 ? LEN_W'(2) : LEN_W'(1));
        end
    end

endmodule

// File: rtl/mojo_serial_line_in.sv
// Receive-side CR/LF line framer. It collects UART bytes until CR LF and then
// presents the payload as one wide block with a byte count. Lines longer than
// MAX_BYTES are dropped and flagged with an overflow pulse.
// Optional build macro MOJO_SERIAL_LINE_IN_TIMEOUT_EN discards a partial line
// after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   rx_data       received byte, qualified by new_rx_data
//   new_rx_data   single-cycle byte strobe
//   rx_block      completed line payload, first byte in the top bits
//   rx_len        payload byte count of rx_block
//   new_rx_block  single-cycle pulse when rx_block/rx_len are updated
//   overflow      single-cycle pulse when a line is dropped for length
module mojo_serial_line_in
    import mojo_serial_pkg::*;
#(
    parameter int unsigned MAX_BYTES      = 40,
    parameter int unsigned LEN_W          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   new_rx_data,
    output logic [MAX_BYTES*8-1:0] rx_block,
    output logic [LEN_W-1:0]       rx_len,
    output logic                   new_rx_block,
    output logic                   overflow
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((2 ** LEN_W) <= MAX_BYTES) begin : g_bad_len_w
        $error("LEN_W too narrow for MAX_BYTES");
    end

    line_state_t            state;
    logic [MAX_BYTES*8-1:0] line_buf;
    logic [LEN_W-1:0]       line_count;
    logic                   line_full;
    logic                   room2;
    logic                   buf_clear;
    logic                   append1;
    logic                   append2;
    logic [7:0]             byte_a;
    logic [7:0]             byte_b;
    logic                   emit;
    logic                   ovf;
    logic                   timeout_hit;

    // Space for a held CR plus the byte that followed it.
    assign room2 = ({1'b0, line_count} + (LEN_W+1)'(2)) <= (LEN_W+1)'(MAX_BYTES);

`ifdef MOJO_SERIAL_LINE_IN_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] idle_cnt;
    logic             timer_active;

    assign timer_active = (state != COLLECT) || (line_count != '0);
    assign timeout_hit  = timer_active && !new_rx_data &&
                          (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || new_rx_data || !timer_active || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TMR_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Buffer commands and event flags for the current byte.
    always_comb begin
        buf_clear = timeout_hit;
        append1   = 1'b0;
        append2   = 1'b0;
        byte_a    = rx_data;
        byte_b    = rx_data;
        emit      = 1'b0;
        ovf       = 1'b0;
        if (new_rx_data) begin
            case (state)
                COLLECT: begin
                    if (rx_data != ASCII_CR) begin
                        if (!line_full) append1 = 1'b1;
                        else            ovf     = 1'b1;
                    end
                end
                GOT_CR: begin
                    byte_a = ASCII_CR;
                    if (rx_data == ASCII_LF) begin
                        buf_clear = 1'b1;
                        emit      = (line_count != '0);
                    end else if (rx_data == ASCII_CR) begin
                        if (!line_full) append1 = 1'b1;
                        else            ovf     = 1'b1;
                    end else begin
                        if (room2) append2 = 1'b1;
                        else       ovf     = 1'b1;
                    end
                end
                DISCARD_CR: begin
                    if (rx_data == ASCII_LF) buf_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mojo_line_buffer #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (buf_clear),
        .append1  (append1),
        .append2  (append2),
        .byte_a   (byte_a),
        .byte_b   (byte_b),
        .line_buf (line_buf),
        .count    (line_count),
        .full     (line_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= COLLECT;
            rx_block     <= '0;
            rx_len       <= '0;
            new_rx_block <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            new_rx_block <= emit;
            overflow     <= ovf;
            if (emit) begin
                rx_block <= line_buf;
                rx_len   <= line_count;
            end
            if (timeout_hit) begin
                state <= COLLECT;
            end else if (new_rx_data) begin
                case (state)
                    COLLECT: begin
                        if (rx_data == ASCII_CR) state <= GOT_CR;
                        else if (line_full)      state <= DISCARD;
                    end
                    GOT_CR: begin
                        if (rx_data == ASCII_LF)      state <= COLLECT;
                        else if (rx_data == ASCII_CR) state <= line_full ? DISCARD : GOT_CR;
                        else                          state <= room2 ? COLLECT : DISCARD;
                    end
                    DISCARD: begin
                        if (rx_data == ASCII_CR) state <= DISCARD_CR;
                    end
                    DISCARD_CR: begin
                        if (rx_data == ASCII_LF)      state <= COLLECT;
                        else if (rx_data != ASCII_CR) state <= DISCARD;
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mojo_serial_line_in.sv
// Directed testbench for mojo_serial_line_in (MAX_BYTES=40, TIMEOUT_CYCLES=100).
module tb_mojo_serial_line_in;

    localparam int unsigned MB = 40;
    localparam int unsigned LW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            new_rx_data = 1'b0;
    logic [MB*8-1:0] rx_block;
    logic [LW-1:0]   rx_len;
    logic            new_rx_block;
    logic            overflow;

    int compared   = 0;
    int mismatched = 0;
    int blk_pulses = 0;
    int ovf_pulses = 0;
    int both_pulses = 0;

    logic [MB*8-1:0] exp_blk;

    always #5 clk = ~clk;

    mojo_serial_line_in #(
        .MAX_BYTES      (MB),
        .LEN_W          (LW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .new_rx_data  (new_rx_data),
        .rx_block     (rx_block),
        .rx_len       (rx_len),
        .new_rx_block (new_rx_block),
        .overflow     (overflow)
    );

    always @(negedge clk) begin
        if (new_rx_block === 1'b1) blk_pulses++;
        if (overflow === 1'b1) ovf_pulses++;
        if (new_rx_block === 1'b1 && overflow === 1'b1) both_pulses++;
    end

    task automatic check(input string tag, input logic [MB*8-1:0] obs, input logic [MB*8-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one strobed byte; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses_before;

        // Reset state
        rst_n = 1'b0;
        idle(3);
        check("reset_block", rx_block, '0);
        check("reset_len", rx_len, '0);
        check("reset_nrb", new_rx_block, '0);
        check("reset_ovf", overflow, '0);
        rst_n = 1'b1;
        idle(1);

        // "AB" CR LF
        send(8'h41); send(8'h42); send(8'h0D);
        check("ab_no_early", new_rx_block, 1'b0);
        send(8'h0A);
        exp_blk = '0;
        exp_blk[MB*8-1 -: 16] = 16'h4142;
        check("ab_nrb", new_rx_block, 1'b1);
        check("ab_len", rx_len, 2);
        check("ab_block", rx_block, exp_blk);
        idle(1);
        check("ab_pulse_width", new_rx_block, 1'b0);
        check("ab_hold", rx_block, exp_blk);

        // Exactly 40 bytes 30..57
        exp_blk = '0;
        for (int i = 0; i < 40; i++) begin
            send(8'h30 + 8'(i));
            exp_blk[8*(MB-i)-1 -: 8] = 8'h30 + 8'(i);
        end
        send(8'h0D); send(8'h0A);
        check("full_nrb", new_rx_block, 1'b1);
        check("full_len", rx_len, 40);
        check("full_first", rx_block[319:312], 8'h30);
        check("full_last", rx_block[7:0], 8'h57);
        check("full_block", rx_block, exp_blk);
        check("full_no_ovf", ovf_pulses, 0);

        // 41 bytes: overflow on the 41st, line dropped
        for (int i = 0; i < 40; i++) send(8'h61);
        check("ovf_not_yet", overflow, 1'b0);
        send(8'h62);
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_no_nrb", new_rx_block, 1'b0);
        idle(1);
        check("ovf_pulse_width", overflow, 1'b0);
        pulses_before = blk_pulses;
        send(8'h0D); send(8'h0A);
        idle(1);
        check("ovf_line_dropped", blk_pulses, pulses_before);
        send(8'h5A); send(8'h0D); send(8'h0A);
        exp_blk = '0;
        exp_blk[MB*8-1 -: 8] = 8'h5A;
        check("after_ovf_len", rx_len, 1);
        check("after_ovf_block", rx_block, exp_blk);
        check("ovf_once", ovf_pulses, 1);

        // Embedded CRs and bare LF: "A",0D,"B",0D,0D,0A,0A,0D,0A
        send(8'h41); send(8'h0D); send(8'h42); send(8'h0D); send(8'h0D); send(8'h0A);
        exp_blk = '0;
        exp_blk[MB*8-1 -: 32] = 32'h410D420D;
        check("cr_nrb", new_rx_block, 1'b1);
        check("cr_len", rx_len, 4);
        check("cr_block", rx_block, exp_blk);
        send(8'h0A); send(8'h0D); send(8'h0A);
        exp_blk = '0;
        exp_blk[MB*8-1 -: 8] = 8'h0A;
        check("lf_nrb", new_rx_block, 1'b1);
        check("lf_len", rx_len, 1);
        check("lf_block", rx_block, exp_blk);

        // Empty line
        idle(1);
        pulses_before = blk_pulses;
        send(8'h0D); send(8'h0A);
        idle(2);
        check("empty_no_pulse", blk_pulses, pulses_before);

        // Reset mid-line discards "XY"
        send(8'h58); send(8'h59);
        rst_n = 1'b0;
        idle(1);
        check("midrst_block", rx_block, '0);
        check("midrst_len", rx_len, '0);
        rst_n = 1'b1;
        send(8'h51); send(8'h0D); send(8'h0A);
        exp_blk = '0;
        exp_blk[MB*8-1 -: 8] = 8'h51;
        check("q_len", rx_len, 1);
        check("q_block", rx_block, exp_blk);

        // Idle gap of 100 cycles inside a line
        send(8'h41); send(8'h42);
        idle(100);
        send(8'h43); send(8'h0D); send(8'h0A);
        exp_blk = '0;
`ifdef MOJO_SERIAL_LINE_IN_TIMEOUT_EN
        exp_blk[MB*8-1 -: 8] = 8'h43;
        check("gap_len", rx_len, 1);
`else
        exp_blk[MB*8-1 -: 24] = 24'h414243;
        check("gap_len", rx_len, 3);
`endif
        check("gap_block", rx_block, exp_blk);

        idle(2);
        check("total_emissions", blk_pulses, 7);
        check("total_overflows", ovf_pulses, 1);
        check("never_both", both_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
